// File: rtl/sdp_ram_2k_x8_pkg.sv
// Shared sizing defaults and reset-style enumeration for the 2k x 8 simple dual-port RAM.
// Pure declarations: no latency, no flow control.
package sdp_ram_2k_x8_pkg;

    localparam int ADDR_WIDTH_DEF = 11;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

    // Only RST_ASYNC is built today; the others reserve names for later output-reg styles.
    typedef enum logic [1:0] {
        RST_ASYNC                    = 2'd0,
        RST_SYNC                     = 2'd1,
        RST_ASYNC_RESET_SYNC_RELEASE = 2'd2
    } reset_type_e;

endpackage

// File: rtl/sdp_ram_out_reg.sv
// Optional second read-output register stage with asynchronous active-high clear.
// Latency: 1 clk. No backpressure: captures d on every clock edge.
module sdp_ram_out_reg
    import sdp_ram_2k_x8_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sdp_ram_2k_x8.sv
// Simple dual-port block RAM, independent write/read clocks, registered read.
// Latency: 1 rd_clk (OUTPUT_REG=0) or 2 (OUTPUT_REG=1). No backpressure: one write and one read per cycle.
module sdp_ram_2k_x8
    import sdp_ram_2k_x8_pkg::*;
#(
    parameter int    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int    OUTPUT_REG = 0,
    parameter string RESET_TYPE = "ASYNC"
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (RESET_TYPE != "ASYNC") begin : g_bad_reset_type
            $error("sdp_ram_2k_x8: only ASYNC read-register reset is implemented");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_q;

    // Write reset is a pure gate so the array keeps no reset and maps onto block RAM.
    always_ff @(posedge wr_clk) begin
        if (wr_en && !tb_wr_rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-first on a same-edge collision falls out of the non-blocking update order.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    generate
        if (OUTPUT_REG == 1) begin : g_out_reg
            sdp_ram_out_reg #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_out_reg (
                .clk (rd_clk),
                .rst (rd_rst),
                .d   (rd_q),
                .q   (rd_data)
            );
        end else begin : g_no_out_reg
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_2k_x8.sv
// Directed bench for sdp_ram_2k_x8: latency-1 and latency-2 instances share one clock and all inputs.
module tb_sdp_ram_2k_x8;

    logic        clk = 1'b0;
    logic        tb_wr_rst;
    logic        rd_rst;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  rd_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_ram_2k_x8 #(.OUTPUT_REG(0)) u_dut (
        .wr_clk    (clk),
        .tb_wr_rst (tb_wr_rst),
        .rd_clk    (clk),
        .rd_rst    (rd_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    sdp_ram_2k_x8 #(.OUTPUT_REG(1)) u_dut2 (
        .wr_clk    (clk),
        .tb_wr_rst (tb_wr_rst),
        .rd_clk    (clk),
        .rd_rst    (rd_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data2)
    );

    task automatic write_word(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        tb_wr_rst = 1'b1;
        rd_rst    = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 11'd7;
        wr_data   = 8'h99;
        rd_addr   = 11'd7;
        #100;
        checks++;
        if (rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        checks++;
        if (rd_data2 !== 8'h00) begin
            errors++; $display("FAIL reset_rd_data_reg2: got %h expected 00", rd_data2);
        end
        #100;
        @(negedge clk);
        tb_wr_rst = 1'b0;
        rd_rst    = 1'b0;
        wr_en     = 1'b0;
        #1;
        checks++;
        if (rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_release_hold: got %h expected 00", rd_data);
        end
        write_word(11'd7, 8'h42);
        // Attempted overwrite while only the write reset is asserted.
        @(negedge clk);
        tb_wr_rst = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 11'd7;
        wr_data   = 8'h99;
        repeat (2) @(negedge clk);
        wr_en     = 1'b0;
        tb_wr_rst = 1'b0;
        rd_addr   = 11'd7;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h42) begin
            errors++; $display("FAIL wr_rst_gating: got %h expected 42", rd_data);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 11'(k + 1);
            wr_data = 8'hFF - 8'(k);
        end
        @(negedge clk);
        wr_en   = 1'b0;
        for (int k = 0; k < 2048; k++) begin
            rd_addr = 11'(k + 1);
            @(negedge clk);
            checks++;
            if (rd_data !== (8'hFF - 8'(k))) begin
                errors++;
                $display("FAIL fill_readback addr %0d: got %h expected %h", k + 1, rd_data, 8'hFF - 8'(k));
            end
        end
    endtask

    task automatic test_latency();
        write_word(11'h123, 8'hA5);
        // Address 0 holds 0x00 from the fill (last step, k = 2047).
        rd_addr = 11'h000;
        repeat (3) @(negedge clk);
        rd_addr = 11'h123;
        @(posedge clk); #1;
        checks++;
        if (rd_data !== 8'hA5) begin
            errors++; $display("FAIL latency1_edgeN: got %h expected a5", rd_data);
        end
        checks++;
        if (rd_data2 !== 8'h00) begin
            errors++; $display("FAIL latency2_edgeN: got %h expected 00", rd_data2);
        end
        @(negedge clk);
        rd_addr = 11'h000;
        checks++;
        if (rd_data !== 8'hA5) begin
            errors++; $display("FAIL latency1_hold: got %h expected a5", rd_data);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_data !== 8'h00) begin
            errors++; $display("FAIL latency1_edgeN1: got %h expected 00", rd_data);
        end
        checks++;
        if (rd_data2 !== 8'hA5) begin
            errors++; $display("FAIL latency2_edgeN1: got %h expected a5", rd_data2);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_data2 !== 8'h00) begin
            errors++; $display("FAIL latency2_edgeN2: got %h expected 00", rd_data2);
        end
    endtask

    task automatic test_wr_en_gating();
        write_word(11'd5, 8'h3C);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = 11'd5;
        wr_data = 8'hFF;
        rd_addr = 11'd5;
        repeat (2) @(negedge clk);
        checks++;
        if (rd_data !== 8'h3C) begin
            errors++; $display("FAIL wr_en_gating: got %h expected 3c", rd_data);
        end
    endtask

    task automatic test_rd_reset_mid();
        write_word(11'd9, 8'h5A);
        rd_addr = 11'd9;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h5A) begin
            errors++; $display("FAIL rd_rst_pre: got %h expected 5a", rd_data);
        end
        #2 rd_rst = 1'b1;
        #1;
        checks++;
        if (rd_data !== 8'h00) begin
            errors++; $display("FAIL rd_rst_immediate: got %h expected 00", rd_data);
        end
        @(negedge clk);
        rd_rst = 1'b0;
        #1;
        checks++;
        if (rd_data !== 8'h00 || rd_data2 !== 8'h00) begin
            errors++; $display("FAIL rd_rst_release_hold: got %h/%h expected 00/00", rd_data, rd_data2);
        end
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h5A) begin
            errors++; $display("FAIL rd_rst_after: got %h expected 5a", rd_data);
        end
        @(negedge clk);
        checks++;
        if (rd_data2 !== 8'h5A) begin
            errors++; $display("FAIL rd_rst_after_reg2: got %h expected 5a", rd_data2);
        end
    endtask

    task automatic test_collision();
        write_word(11'h020, 8'h11);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 11'h020;
        wr_data = 8'h77;
        rd_addr = 11'h020;
        @(negedge clk);
        wr_en   = 1'b0;
        checks++;
        if (rd_data !== 8'h11) begin
            errors++; $display("FAIL collision_read_first: got %h expected 11", rd_data);
        end
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h77) begin
            errors++; $display("FAIL collision_new_value: got %h expected 77", rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_latency();
        test_wr_en_gating();
        test_rd_reset_mid();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
